// File: rtl/toggle_pkg.sv
// +--------------------------------------------------------------------------+
// | toggle_pkg : shared encodings for the toggle_bank channel FSMs             |
// | Revision   : 1.0                                                           |
// +--------------------------------------------------------------------------+
`default_nettype none

package toggle_pkg;

  localparam int STATE_W = 2;

  // Named as lamp state _ debounced button level.
  typedef enum logic [STATE_W-1:0] {
    OFF_0 = 2'b00,
    ON_1  = 2'b01,
    ON_0  = 2'b10,
    OFF_1 = 2'b11
  } state_t;

  typedef enum logic {
    MODE_TOGGLE    = 1'b0,
    MODE_MOMENTARY = 1'b1
  } mode_t;

  function automatic logic state_is_on(state_t s);
    return (s == ON_1) || (s == ON_0);
  endfunction

endpackage

`default_nettype wire

// File: rtl/toggle_channel.sv
// +--------------------------------------------------------------------------+
// | toggle_channel : one button channel - optional synchronizer, debouncer,    |
// |                  toggle/momentary FSM and press strobe.                    |
// | Config         : TOGGLE_BANK_SYNC_EN adds a 2-flop input synchronizer.     |
// | Revision       : 1.0                                                       |
// +--------------------------------------------------------------------------+
`default_nettype none

module toggle_channel
  import toggle_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic n_reset,
  input  logic ip_signal,
  input  logic mode,
  input  logic clear,
  output logic op_signal,
  output logic press_pulse
);

  localparam int                 C_CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [C_CNT_W-1:0] C_CNT_LAST = C_CNT_W'(DEBOUNCE_CYCLES - 1);

  logic               w_sample;
  logic               r_level;
  logic [C_CNT_W-1:0] r_cnt;
  logic               r_level_q;
  logic               r_pulse;
  state_t             r_state;

`ifdef TOGGLE_BANK_SYNC_EN
  logic [1:0] r_sync;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) r_sync <= '0;
    else          r_sync <= {r_sync[0], ip_signal};
  end

  assign w_sample = r_sync[1];
`else
  assign w_sample = ip_signal;
`endif

  // Level flips on the DEBOUNCE_CYCLES-th consecutive differing sample.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_level <= 1'b0;
      r_cnt   <= '0;
    end else if (w_sample == r_level) begin
      r_cnt   <= '0;
    end else if (r_cnt == C_CNT_LAST) begin
      r_level <= ~r_level;
      r_cnt   <= '0;
    end else begin
      r_cnt   <= r_cnt + C_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_state   <= OFF_0;
      r_level_q <= 1'b0;
      r_pulse   <= 1'b0;
    end else begin
      r_level_q <= r_level;
      r_pulse   <= r_level & ~r_level_q & ~clear;
      if (clear) begin
        // Loading OFF_1 for a held button keeps it from re-toggling.
        r_state <= r_level ? OFF_1 : OFF_0;
      end else if (mode == MODE_MOMENTARY) begin
        r_state <= r_level ? ON_1 : OFF_0;
      end else begin
        case (r_state)
          OFF_0:   if (r_level)  r_state <= ON_1;
          ON_1:    if (!r_level) r_state <= ON_0;
          ON_0:    if (r_level)  r_state <= OFF_1;
          OFF_1:   if (!r_level) r_state <= OFF_0;
          default: r_state <= OFF_0;
        endcase
      end
    end
  end

  assign op_signal   = state_is_on(r_state);
  assign press_pulse = r_pulse;

endmodule

`default_nettype wire

// File: rtl/toggle_bank.sv
// +--------------------------------------------------------------------------+
// | toggle_bank : bank of CHANNELS independent debounced toggle/momentary     |
// |               button channels with press strobes.                        |
// | Config      : TOGGLE_BANK_SYNC_EN adds a 2-flop input synchronizer.       |
// | Revision    : 1.0                                                         |
// +--------------------------------------------------------------------------+
`default_nettype none

module toggle_bank #(
  parameter int CHANNELS        = 4,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                clk,
  input  logic                n_reset,
  input  logic [CHANNELS-1:0] ip_signal,
  input  logic [CHANNELS-1:0] mode,
  input  logic                clear,
  output logic [CHANNELS-1:0] op_signal,
  output logic [CHANNELS-1:0] press_pulse
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_channel
    toggle_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_channel (
      .clk        (clk),
      .n_reset    (n_reset),
      .ip_signal  (ip_signal[i]),
      .mode       (mode[i]),
      .clear      (clear),
      .op_signal  (op_signal[i]),
      .press_pulse(press_pulse[i])
    );
  end

endmodule

`default_nettype wire
